// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
//   Shared definitions for the Gray counter slice.
//   - GRAY_SIZE_MIN / GRAY_SIZE_MAX : legal bounds for the SIZE parameter
//   - bin_to_gray()                 : binary to reflected-binary Gray code,
//                                     32 bits wide; callers zero-extend their
//                                     operand and truncate the result.
// -----------------------------------------------------------------------------
package gray_pkg;

  localparam int GRAY_SIZE_MIN = 2;
  localparam int GRAY_SIZE_MAX = 32;

  // Gray MSB equals binary MSB; every lower bit is b[i+1] ^ b[i].
  function automatic logic [31:0] bin_to_gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage : gray_pkg

// File: rtl/gray_decoder.sv
// -----------------------------------------------------------------------------
// gray_decoder
//   Purely combinational Gray-to-binary converter, for checking the counter
//   and for downstream consumers that receive the Gray count across a clock
//   domain boundary.
//
//   Parameters
//     SIZE    code width in bits
//   Ports
//     gray    input  [SIZE-1:0]  Gray-coded value
//     binary  output [SIZE-1:0]  equivalent binary value
// -----------------------------------------------------------------------------
module gray_decoder #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] gray,
  output logic [SIZE-1:0] binary
);

  // Binary bit i is the XOR of all Gray bits from i up to the MSB. Each bit is
  // written as an independent reduction instead of a ripple through binary[i+1],
  // so the block has no self-dependency.
  always_comb begin
    // NOTE: every variable driven in always_comb gets a default before any
    // conditional or loop assignment, so no path can infer a latch.
    binary = '0;
    for (int i = 0; i < SIZE; i++) begin
      binary[i] = ^(gray >> i);
    end
  end

endmodule : gray_decoder

// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
//   Up/down binary counter with a registered Gray-coded copy of the count.
//   Edge priority: reset > load_in > enable_in > hold.
//
//   Parameters
//     SIZE      counter width in bits (2..32)
//     SATURATE  0 = wrap at the ends, 1 = hold at the ends
//   Ports
//     clk               input           rising-edge clock
//     reset             input           synchronous, active-high reset
//     enable_in         input           advance by one step this edge
//     direction_in      input           1 = up, 0 = down
//     load_in           input           load load_value_in this edge
//     load_value_in     input  [SIZE]   binary value to load
//     count_binary_out  output [SIZE]   registered binary count
//     count_gray_out    output [SIZE]   registered Gray form of the count
//     terminal_out      output          count is at the end for direction_in
//     wrap_out          output          one-cycle pulse after a wrapping step
//                                       (only with GRAY_COUNTER_WRAP_FLAG_EN)
//
//   Build option
//     GRAY_COUNTER_WRAP_FLAG_EN  compiles in wrap_out and its register.
// -----------------------------------------------------------------------------
module gray_counter
  import gray_pkg::*;
#(
  parameter int SIZE     = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable_in,
  input  logic            direction_in,
  input  logic            load_in,
  input  logic [SIZE-1:0] load_value_in,
  output logic [SIZE-1:0] count_binary_out,
  output logic [SIZE-1:0] count_gray_out,
`ifdef GRAY_COUNTER_WRAP_FLAG_EN
  output logic            wrap_out,
`endif
  output logic            terminal_out
);

  generate
    if (SIZE < GRAY_SIZE_MIN || SIZE > GRAY_SIZE_MAX) begin : g_bad_size
      $error("gray_counter: SIZE must be within 2..32");
    end
  endgenerate

  logic            at_max;
  logic            at_min;
  logic            at_end;
  logic [SIZE-1:0] next_bin;
  logic [SIZE-1:0] next_gray;
  logic [SIZE-1:0] decoded;

  assign at_max       = &count_binary_out;
  assign at_min       = ~|count_binary_out;
  assign at_end       = direction_in ? at_max : at_min;
  assign terminal_out = at_end;

  always_comb begin
    next_bin = count_binary_out;
    if (load_in) begin
      next_bin = load_value_in;
    end else if (enable_in) begin
      if (SATURATE && at_end) begin
        next_bin = count_binary_out;
      end else if (direction_in) begin
        next_bin = count_binary_out + SIZE'(1);
      end else begin
        next_bin = count_binary_out - SIZE'(1);
      end
    end
  end

  // The Gray register is fed from the next binary value, not decoded from the
  // output register, so both registers change on the same edge and the Gray
  // output never glitches through an intermediate code.
  assign next_gray = SIZE'(bin_to_gray(32'(next_bin)));

  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of statement order.
    if (reset) begin
      count_binary_out <= '0;
      count_gray_out   <= '0;
    end else begin
      count_binary_out <= next_bin;
      count_gray_out   <= next_gray;
    end
  end

`ifdef GRAY_COUNTER_WRAP_FLAG_EN
  // A wrap only happens on an enabled, non-load step taken from the end
  // position; saturating builds never wrap.
  logic step_wraps;
  assign step_wraps = !load_in && enable_in && at_end && !SATURATE;

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_out <= 1'b0;
    end else begin
      wrap_out <= step_wraps;
    end
  end
`endif

  // Decoded view of the Gray register; the two registers must always agree.
  gray_decoder #(
    .SIZE (SIZE)
  ) u_decoder (
    .gray   (count_gray_out),
    .binary (decoded)
  );

  a_gray_matches_binary : assert property (
    @(posedge clk) disable iff (reset) decoded == count_binary_out
  );

endmodule : gray_counter

// File: tb/tb_gray_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_counter
//   Directed bench for gray_counter with SIZE=4: instance u_wrap (SATURATE=0)
//   and instance u_sat (SATURATE=1) share one set of stimulus inputs.
//   Ends with a seeded random phase checked against a small reference model.
// -----------------------------------------------------------------------------
module tb_gray_counter;

  localparam int SIZE = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable_in;
  logic            direction_in;
  logic            load_in;
  logic [SIZE-1:0] load_value_in;

  logic [SIZE-1:0] bin_a, gray_a, dec_a;
  logic [SIZE-1:0] bin_b, gray_b, dec_b;
  logic            term_a, term_b;
`ifdef GRAY_COUNTER_WRAP_FLAG_EN
  logic            wrap_a, wrap_b;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_counter #(.SIZE(SIZE), .SATURATE(1'b0)) u_wrap (
    .clk              (clk),
    .reset            (reset),
    .enable_in        (enable_in),
    .direction_in     (direction_in),
    .load_in          (load_in),
    .load_value_in    (load_value_in),
    .count_binary_out (bin_a),
    .count_gray_out   (gray_a),
`ifdef GRAY_COUNTER_WRAP_FLAG_EN
    .wrap_out         (wrap_a),
`endif
    .terminal_out     (term_a)
  );

  gray_counter #(.SIZE(SIZE), .SATURATE(1'b1)) u_sat (
    .clk              (clk),
    .reset            (reset),
    .enable_in        (enable_in),
    .direction_in     (direction_in),
    .load_in          (load_in),
    .load_value_in    (load_value_in),
    .count_binary_out (bin_b),
    .count_gray_out   (gray_b),
`ifdef GRAY_COUNTER_WRAP_FLAG_EN
    .wrap_out         (wrap_b),
`endif
    .terminal_out     (term_b)
  );

  gray_decoder #(.SIZE(SIZE)) u_dec_a (.gray(gray_a), .binary(dec_a));
  gray_decoder #(.SIZE(SIZE)) u_dec_b (.gray(gray_b), .binary(dec_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SIZE-1:0] model_next(input logic [SIZE-1:0] c, input bit sat,
                                                 input bit en, input bit dir, input bit ld,
                                                 input logic [SIZE-1:0] v);
    if (ld) return v;
    if (!en) return c;
    if (dir) return (c == 4'hF) ? (sat ? 4'hF : 4'h0) : c + 4'h1;
    return (c == 4'h0) ? (sat ? 4'h0 : 4'hF) : c - 4'h1;
  endfunction

  function automatic logic [SIZE-1:0] to_gray(input logic [SIZE-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [SIZE-1:0] up_gray [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                    4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  initial begin
    logic [SIZE-1:0] ma, mb, pa, pb, pga, pgb;
    bit en, dir, ld;
    logic [SIZE-1:0] v;
    int wrap_pulses;

    reset = 1'b1; enable_in = 1'b0; direction_in = 1'b0; load_in = 1'b0; load_value_in = '0;
    tick();

    // Reset state and the direction-dependent terminal flag.
    check("reset_bin", bin_a, 0);
    check("reset_gray", gray_a, 0);
    check("reset_term_down", term_a, 1);
`ifdef GRAY_COUNTER_WRAP_FLAG_EN
    check("reset_wrap", wrap_a, 0);
`endif
    direction_in = 1'b1; #1;
    check("reset_term_up", term_a, 0);

    // Count up 16 steps through the full Gray sequence and back to zero.
    reset = 1'b0; enable_in = 1'b1;
    wrap_pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("up_gray", gray_a, up_gray[k-1]);
      check("up_bin", bin_a, k % 16);
      if (k == 15) check("up_term_at_max", term_a, 1);
`ifdef GRAY_COUNTER_WRAP_FLAG_EN
      if (wrap_a) wrap_pulses++;
`endif
    end
`ifdef GRAY_COUNTER_WRAP_FLAG_EN
    check("up_wrap_after_16", wrap_a, 1);
    check("up_wrap_pulses", wrap_pulses, 1);
`endif
    check("sat_up_hold_bin", bin_b, 4'hF);
    check("sat_up_hold_gray", gray_b, 4'h8);

    // Reset, then count down one step: wraps to 1111 / 1000.
    reset = 1'b1; enable_in = 1'b0; direction_in = 1'b0;
    tick();
    reset = 1'b0; enable_in = 1'b1;
    tick();
    check("down1_bin", bin_a, 4'hF);
    check("down1_gray", gray_a, 4'h8);
    check("down1_term", term_a, 0);
    check("sat_down_hold_bin", bin_b, 0);
    check("sat_down_term", term_b, 1);
`ifdef GRAY_COUNTER_WRAP_FLAG_EN
    check("down1_wrap", wrap_a, 1);
    check("sat_down_no_wrap", wrap_b, 0);
`endif
    for (int k = 2; k <= 16; k++) begin
      tick();
      check("down_bin", bin_a, (16 - k) % 16);
      check("down_term", term_a, (k == 16) ? 1 : 0);
    end

    // Load beats enable: from 3, loading 9 with enable high gives 9, not 10.
    enable_in = 1'b0; load_in = 1'b1; load_value_in = 4'd3;
    tick();
    check("load3_bin", bin_a, 3);
    load_value_in = 4'd9; enable_in = 1'b1; direction_in = 1'b1;
    tick();
    check("load9_bin", bin_a, 4'h9);
    check("load9_gray", gray_a, 4'hD);
`ifdef GRAY_COUNTER_WRAP_FLAG_EN
    check("load_no_wrap", wrap_a, 0);
`endif

    // Saturating instance holds at 1111 while counting up.
    enable_in = 1'b0; load_value_in = 4'hF;
    tick();
    load_in = 1'b0; enable_in = 1'b1; direction_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("sat_bin", bin_b, 4'hF);
      check("sat_gray", gray_b, 4'h8);
      check("sat_term", term_b, 1);
`ifdef GRAY_COUNTER_WRAP_FLAG_EN
      check("sat_no_wrap", wrap_b, 0);
`endif
    end
    check("wrap_inst_after_3", bin_a, 2);

    // Hold, then reset overriding load and enable.
    enable_in = 1'b0; load_in = 1'b1; load_value_in = 4'd6;
    tick();
    load_in = 1'b0;
    tick();
    tick();
    check("hold_bin", bin_a, 6);
    check("hold_gray", gray_a, 4'h5);
    reset = 1'b1; load_in = 1'b1; enable_in = 1'b1; load_value_in = 4'd9;
    tick();
    check("reset_override_bin", bin_a, 0);
    check("reset_override_gray", gray_a, 0);

    // Random enable/direction/load traffic against a reference model.
    reset = 1'b0; load_in = 1'b0; enable_in = 1'b0;
    ma = '0; mb = '0;
    for (int k = 0; k < 200; k++) begin
      en  = ($urandom_range(0, 3) != 0);
      dir = $urandom_range(0, 1) == 1;
      ld  = ($urandom_range(0, 9) == 0);
      v   = 4'($urandom_range(0, 15));
      enable_in = en; direction_in = dir; load_in = ld; load_value_in = v;
      pa = ma; pb = mb; pga = gray_a; pgb = gray_b;
      ma = model_next(ma, 1'b0, en, dir, ld, v);
      mb = model_next(mb, 1'b1, en, dir, ld, v);
      tick();
      check("rnd_bin_a", bin_a, ma);
      check("rnd_gray_a", gray_a, to_gray(ma));
      check("rnd_bin_b", bin_b, mb);
      check("rnd_gray_b", gray_b, to_gray(mb));
      check("rnd_dec_a", dec_a, bin_a);
      check("rnd_dec_b", dec_b, bin_b);
      check("rnd_term_b", term_b, dir ? (mb == 4'hF) : (mb == 4'h0));
      if (!ld) begin
        check("rnd_step_a", $countones(pga ^ gray_a), en ? 1 : 0);
        check("rnd_step_b", $countones(pgb ^ gray_b), (en && pb != mb) ? 1 : 0);
      end
`ifdef GRAY_COUNTER_WRAP_FLAG_EN
      check("rnd_wrap_a", wrap_a, (!ld && en && (dir ? pa == 4'hF : pa == 4'h0)) ? 1 : 0);
      check("rnd_wrap_b", wrap_b, 0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_gray_counter

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter SIZE, default 4, counter width in bits; legal range 2..32.
REQ-002 SHALL have parameter SATURATE, default 0; 0 = wrap at ends, 1 = hold at ends.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable_in  input  1  advance count by one step when high.
REQ-006 SHALL have port direction_in  input  1  1 = count up, 0 = count down.
REQ-007 SHALL have port load_in  input  1  load load_value_in on this edge.
REQ-008 SHALL have port load_value_in  input  SIZE  binary value to load.
REQ-009 SHALL have port count_binary_out  output  SIZE  registered binary count.
REQ-010 SHALL have port count_gray_out  output  SIZE  registered Gray form of count.
REQ-011 SHALL have port terminal_out  output  1  high when count is at the end for the current direction_in (all-ones if up, zero if down); combinational from registers and direction_in.
REQ-012 SHALL have port wrap_out  output  1  present only with GRAY_COUNTER_WRAP_FLAG_EN (REQ-026).

Function
REQ-013 SHALL apply per-edge priority: reset > load_in > enable_in > hold.
REQ-014 SHALL load load_value_in into count_binary_out and bin^(bin>>1) into count_gray_out on the edge where load_in=1, regardless of enable_in and direction_in; 1-cycle latency.
REQ-015 SHALL, with enable_in=1 and load_in=0, set the next binary count to count+1 (up) or count-1 (down), modulo 2^SIZE when SATURATE=0.
REQ-016 SHALL, with SATURATE=1, hold at 2^SIZE-1 when counting up and at 0 when counting down instead of wrapping.
REQ-017 SHALL register count_gray_out directly from the next binary value (Gray MSB = binary MSB, bit i = b[i+1]^b[i]), in the same edge as count_binary_out; count_gray_out SHALL NOT be decoded combinationally from the output register.
REQ-018 SHALL guarantee that count_gray_out changes in exactly one bit per enabled step, including across wrap, and in zero bits when held or saturated.
REQ-019 SHALL leave both outputs unchanged when enable_in=0 and load_in=0.
REQ-020 SHALL allow direction_in to change on any cycle; the new direction takes effect on that same edge.

Reset
REQ-021 SHALL set count_binary_out=0 and count_gray_out=0 on any edge with reset=1, overriding load_in and enable_in.
REQ-022 SHALL set wrap_out=0 on reset (when compiled in).
REQ-023 SHALL give terminal_out=1 after reset while direction_in=0, and terminal_out=0 while direction_in=1.
REQ-024 SHALL discard an in-progress count on reset mid-operation; no state is retained.

Configuration
REQ-025 SHALL use macro GRAY_COUNTER_WRAP_FLAG_EN to compile the wrap flag in or out.
REQ-026 SHALL, when defined, register wrap_out high for exactly one cycle after an enabled step that wraps (2^SIZE-1 -> 0 up, 0 -> 2^SIZE-1 down); never on load, and never when SATURATE=1.
REQ-027 SHALL, when undefined, omit wrap_out and its register; all other behaviour identical.

Structure
REQ-028 SHALL place the binary-to-Gray function and the SIZE bounds constants in shared package gray_pkg.
REQ-029 SHALL instantiate one sub-module, gray_decoder (Gray-to-binary, parametrised SIZE), used by the bench self-check and available to downstream CDC consumers; the counter datapath itself stays binary.

Verification
REQ-030 SHALL cover: SIZE=4, reset, up, enable 16 cycles -> gray 0000,0001,0011,0010,0110,...,1000,0000; wrap_out pulses once (macro on).
REQ-031 SHALL cover: reset, down, enable 1 cycle -> binary 1111, gray 1000, terminal_out=0 afterwards until count returns to 0.
REQ-032 SHALL cover: count=3, load_in=1, load_value_in=9, enable_in=1 -> next cycle binary 1001, gray 1101, no increment.
REQ-033 SHALL cover: SATURATE=1, load 15, up, enable 3 cycles -> holds 1111/1000, terminal_out=1, wrap_out never high.
REQ-034 SHALL cover: count=6, reset=1 with load_in=1 and enable_in=1 -> next cycle binary 0000, gray 0000.
REQ-035 SHALL cover: 200 random enable/direction/load cycles -> every enabled non-saturated step changes exactly one gray bit, and gray_decoder(count_gray_out) equals count_binary_out every cycle.
